// File: rtl/mode_select_input.sv
`default_nettype none
// ============================================================================
// Module   : mode_select_input
// Purpose  : Cleans up two raw push-buttons for the counter/LED block.
//            Each button is synchronized (2 flops) and debounced (counter
//            filter). A short press of the mode button advances `value`
//            modulo 4, a long press forces it to 0. Each press of the enable
//            button toggles `enable`.
// Ports    : CLK          - single clock, rising edge
//            RST          - synchronous active-high reset
//            btn_mode     - raw mode button (async, high = pressed)
//            btn_en       - raw enable button (async, high = pressed)
//            value[1:0]   - registered mode code
//            enable       - registered enable level
//            mode_changed - registered one-cycle pulse on every write of value
// Revision : 1.0 - initial release
// ============================================================================
module mode_select_input #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btn_mode,
    input  logic       btn_en,
    output logic [1:0] value,
    output logic       enable,
    output logic       mode_changed
);

    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int c_HC_W = $clog2(HOLD_CYCLES);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HC_W-1:0] c_HC_LAST = c_HC_W'(HOLD_CYCLES - 1);

    // Channel 0 = mode button, channel 1 = enable button.
    logic [1:0]             w_raw;
    logic [1:0]             r_meta;
    logic [1:0]             r_sync;
    logic [1:0]             r_deb;
    logic [1:0]             r_deb_q;   // previous debounced level, for edge detect
    logic [1:0][c_DB_W-1:0] r_db_cnt;

    assign w_raw = {btn_en, btn_mode};

    // ------------------------------------------------------------------------
    // Synchronizer + debouncer, identical for both buttons. The counter tracks
    // how many consecutive samples have disagreed with the debounced level;
    // any agreeing sample (a bounce back) restarts it.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_meta   <= '0;
            r_sync   <= '0;
            r_deb    <= '0;
            r_deb_q  <= '0;
            r_db_cnt <= '0;
        end else begin
            r_meta  <= w_raw;
            r_sync  <= r_meta;
            r_deb_q <= r_deb;
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == c_DB_LAST) begin
                    r_deb[i]    <= r_sync[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Enable path: toggle on the debounced rising edge only.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            enable <= 1'b0;
        end else if (r_deb[1] && !r_deb_q[1]) begin
            enable <= ~enable;
        end
    end

    // ------------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_HELD    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_HC_W-1:0] r_hc;
    logic [c_HC_W-1:0] w_hc_nxt;
    logic [1:0]        w_value_nxt;
    logic              w_mc_nxt;
    logic              w_dm;
    logic              w_dm_rise;

    assign w_dm      = r_deb[0];
    assign w_dm_rise = r_deb[0] & ~r_deb_q[0];

    always_comb begin
        w_state_nxt = r_state;
        w_hc_nxt    = r_hc;
        w_value_nxt = value;
        w_mc_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_dm_rise) begin
                    w_state_nxt = S_PRESSED;
                    w_hc_nxt    = '0;
                end
            end
            S_PRESSED: begin
                if (!w_dm) begin
                    // Released before the hold time: short press.
                    w_value_nxt = value + 2'd1;
                    w_mc_nxt    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_hc == c_HC_LAST) begin
                    // Long press clears even when value is already 0.
                    w_value_nxt = 2'd0;
                    w_mc_nxt    = 1'b1;
                    w_state_nxt = S_HELD;
                end else begin
                    w_hc_nxt = r_hc + 1'b1;
                end
            end
            S_HELD: begin
                // Wait for release; the release itself changes nothing.
                if (!w_dm) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_hc         <= '0;
            value        <= 2'd0;
            mode_changed <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hc         <= w_hc_nxt;
            value        <= w_value_nxt;
            mode_changed <= w_mc_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mode_select_input.sv
`default_nettype none
// ============================================================================
// Module   : tb_mode_select_input
// Purpose  : Self-checking bench for mode_select_input. Directed scenarios
//            followed by random bouncy stimulus, compared every cycle against
//            an event-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mode_select_input;

    localparam int DC   = 4;
    localparam int HOLD = 20;

    logic       CLK = 1'b0;
    logic       RST;
    logic       btn_mode;
    logic       btn_en;
    logic [1:0] value;
    logic       enable;
    logic       mode_changed;

    always #5 CLK = ~CLK;

    mode_select_input #(
        .DEBOUNCE_CYCLES(DC),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .btn_mode    (btn_mode),
        .btn_en      (btn_en),
        .value       (value),
        .enable      (enable),
        .mode_changed(mode_changed)
    );

    int errors = 0;
    int checks = 0;

    // ------------------------------------------------------------------------
    // Reference model. A debounced level flips once the last DC synchronized
    // samples all disagree with it; the synchronized sample seen at an edge
    // is the raw input from two edges earlier (0 right after reset).
    // ------------------------------------------------------------------------
    bit         raw_hist [2][64];
    int         m_k;          // edge index since reset release
    bit         m_deb    [2];
    bit         rise_m_p, fall_m_p, rise_e_p;
    bit         in_press, fired;
    int         press_edge;
    logic [1:0] m_value;
    logic       m_enable;
    logic       m_mc;

    function automatic bit sync_at(int b, int k);
        if (k < 2) return 1'b0;
        return raw_hist[b][(k - 2) % 64];
    endfunction

    task automatic model_edge(input bit rm, input bit re, input bit r);
        bit all_diff;
        if (r) begin
            m_k = 0; m_deb[0] = 0; m_deb[1] = 0;
            rise_m_p = 0; fall_m_p = 0; rise_e_p = 0;
            in_press = 0; fired = 0; press_edge = 0;
            m_value = 2'd0; m_enable = 1'b0; m_mc = 1'b0;
            return;
        end
        raw_hist[0][m_k % 64] = rm;
        raw_hist[1][m_k % 64] = re;
        m_mc = 1'b0;
        // Responses to debounced edges from the previous edge.
        if (rise_e_p) m_enable = ~m_enable;
        rise_e_p = 0;
        if (fall_m_p) begin
            if (in_press && !fired) begin
                m_value = m_value + 2'd1;
                m_mc    = 1'b1;
            end
            in_press = 0;
            fall_m_p = 0;
        end else if (in_press && !fired && m_k == press_edge + HOLD) begin
            m_value = 2'd0;
            m_mc    = 1'b1;
            fired   = 1;
        end
        if (rise_m_p) begin
            in_press   = 1;
            fired      = 0;
            press_edge = m_k;
            rise_m_p   = 0;
        end
        // Debounced level update.
        for (int b = 0; b < 2; b++) begin
            all_diff = 1;
            for (int j = 0; j < DC; j++)
                if (sync_at(b, m_k - j) == m_deb[b]) all_diff = 0;
            if (all_diff) begin
                m_deb[b] = ~m_deb[b];
                if (b == 0) begin
                    if (m_deb[0]) rise_m_p = 1; else fall_m_p = 1;
                end else if (m_deb[1]) begin
                    rise_e_p = 1;
                end
            end
        end
        m_k++;
    endtask

    // One clock: drive inputs, model the edge, check all outputs.
    task automatic step(input bit m, input bit e, input bit r);
        btn_mode = m;
        btn_en   = e;
        RST      = r;
        @(posedge CLK);
        model_edge(m, e, r);
        #1;
        checks++;
        assert (value === m_value) else begin
            errors++;
            $error("FAIL value observed=%0d expected=%0d t=%0t", value, m_value, $time);
        end
        checks++;
        assert (enable === m_enable) else begin
            errors++;
            $error("FAIL enable observed=%0d expected=%0d t=%0t", enable, m_enable, $time);
        end
        checks++;
        assert (mode_changed === m_mc) else begin
            errors++;
            $error("FAIL mode_changed observed=%0d expected=%0d t=%0t", mode_changed, m_mc, $time);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int pulses;
    int pidx;
    int eidx;
    int pat     [7] = '{1, 0, 1, 0, 1, 1, 0};
    int exp_seq [5] = '{1, 2, 3, 0, 1};
    int rem_m, rem_e;
    bit lm, le;

    initial begin
        btn_mode = 0; btn_en = 0; RST = 1;

        // Reset with buttons toggling.
        step(1, 1, 1);
        step(0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        chk("reset_value", int'(value), 0);
        chk("reset_enable", int'(enable), 0);
        chk("reset_mc", int'(mode_changed), 0);

        // Bounce rejection.
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            step(pat[i][0], 0, 0);
            pulses += int'(mode_changed);
        end
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            pulses += int'(mode_changed);
        end
        chk("bounce_pulses", pulses, 0);
        chk("bounce_value", int'(value), 0);

        // Five short presses with wrap; pulse lands DC+3 cycles after the
        // raw fall, i.e. on the (DC+2)-th step counting the fall step as 0.
        for (int p = 0; p < 5; p++) begin
            pulses = 0; pidx = -1;
            for (int i = 0; i < 10; i++) begin
                step(1, 0, 0);
                pulses += int'(mode_changed);
            end
            for (int i = 0; i < 10; i++) begin
                step(0, 0, 0);
                if (mode_changed) begin pulses++; pidx = i; end
            end
            chk("short_pulses", pulses, 1);
            chk("short_pulse_at", pidx, DC + 2);
            chk("short_value", int'(value), exp_seq[p]);
        end

        // One more short press to reach value 2.
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        chk("pre_long_value", int'(value), 2);

        // Long press: PRESSED entered at step DC+2, clear HOLD cycles later.
        pulses = 0; pidx = -1;
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0);
            if (mode_changed) begin pulses++; pidx = i; end
        end
        chk("long_pulses", pulses, 1);
        chk("long_pulse_at", pidx, DC + 2 + HOLD);
        chk("long_value", int'(value), 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            pulses += int'(mode_changed);
        end
        chk("long_release_pulses", pulses, 0);
        chk("long_release_value", int'(value), 0);

        // Both buttons together.
        eidx = -1; pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0);
            if (enable && eidx < 0) eidx = i;
            pulses += int'(mode_changed);
        end
        chk("simul_enable_at", eidx, DC + 2);
        chk("simul_pulses_high", pulses, 0);
        pulses = 0; pidx = -1;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            if (mode_changed) begin pulses++; pidx = i; end
        end
        chk("simul_pulse_at", pidx, DC + 2);
        chk("simul_value", int'(value), 1);
        chk("simul_enable", int'(enable), 1);

        // Reset while in PRESSED, keep holding.
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 1);
        chk("midrst_value", int'(value), 0);
        chk("midrst_enable", int'(enable), 0);
        pulses = 0; pidx = -1;
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0);
            if (mode_changed) begin pulses++; pidx = i; end
        end
        chk("midrst_long_pulses", pulses, 1);
        chk("midrst_long_at", pidx, DC + 2 + HOLD);
        for (int i = 0; i < 20; i++) step(0, 0, 0);

        // Random bouncy stimulus on both buttons, occasional reset.
        rem_m = 0; rem_e = 0; lm = 0; le = 0;
        for (int c = 0; c < 3000; c++) begin
            if (rem_m == 0) begin
                lm = ~lm;
                rem_m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(4, 45));
            end
            if (rem_e == 0) begin
                le = ~le;
                rem_e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(4, 30));
            end
            rem_m--;
            rem_e--;
            step(lm, le, ($urandom_range(0, 399) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
